c2_cfg_ctrl: RTL and testbench

Configuration controller for an array of NUM_CELLS C2 logic cells. It receives a serial bit stream and assembles each cell's four data inputs (D00, D01, D10, D11) in a shadow register. When the stream is complete it commits the whole array atomically and asserts the cell enable. It sits between the test/config host and the C2 array, so cells never evaluate a partially loaded configuration.

---
 rtl/c2_cfg_ctrl_if.sv | 31 +++
 rtl/c2_cfg_ctrl.sv | 153 +++++++++++++++
 tb/tb_c2_cfg_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/c2_cfg_ctrl_if.sv
// c2_cfg_ctrl_if: configuration bus between the config host and c2_cfg_ctrl.
//   cfg_start / cfg_abort : host commands (begin/restart, abandon a load)
//   cfg_valid / cfg_bit   : serial bit stream, transferred when cfg_ready is high
//   cfg_ready             : controller accepts a bit this cycle
//   cfg_done              : one-cycle pulse on commit
//   cfg_err               : parity failure flag (C2_CFG_PARITY_EN builds only)
//   cells_en / cell_cfg   : committed configuration for the C2 array
// Modports: master (host side), slave (controller side).
interface c2_cfg_ctrl_if #(
    parameter int NUM_CELLS = 4
);
    logic                     cfg_start;
    logic                     cfg_abort;
    logic                     cfg_valid;
    logic                     cfg_bit;
    logic                     cfg_ready;
    logic                     cfg_done;
    logic                     cfg_err;
    logic                     cells_en;
    logic [4*NUM_CELLS-1:0]   cell_cfg;

    modport master (
        output cfg_start, cfg_abort, cfg_valid, cfg_bit,
        input  cfg_ready, cfg_done, cfg_err, cells_en, cell_cfg
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_valid, cfg_bit,
        output cfg_ready, cfg_done, cfg_err, cells_en, cell_cfg
    );
endinterface

// File: rtl/c2_cfg_ctrl.sv
// c2_cfg_ctrl: serial configuration loader for an array of NUM_CELLS C2 cells.
// Bits are assembled in a shadow register (i-th transferred bit -> shadow[i])
// and the whole array is committed atomically, so the cells never see a
// partially loaded configuration. Cell k occupies cell_cfg[4k+3:4k] as
// {D11,D10,D01,D00}.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : c2_cfg_ctrl_if.slave (start/abort/valid/bit in; ready/done/err/
//          cells_en/cell_cfg out)
//
// Optional feature: define C2_CFG_PARITY_EN to append one even-parity bit
// after the data bits; a parity failure leaves the old configuration in place
// and raises cfg_err. Without it, cfg_err is tied low.
module c2_cfg_ctrl #(
    parameter int NUM_CELLS = 4
) (
    input  logic          clk,
    input  logic          rst,
    c2_cfg_ctrl_if.slave  bus
);
    localparam int TOTAL = 4 * NUM_CELLS;
    localparam int CW    = $clog2(TOTAL + 1);

`ifdef C2_CFG_PARITY_EN
    typedef enum logic [2:0] {IDLE, LOAD, PAR, ACTIVE, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     cnt;
    logic [TOTAL-1:0]  shadow;
    logic [TOTAL-1:0]  shadow_d;
    logic [TOTAL-1:0]  cell_cfg_q;
    logic              cells_en_q;
    logic              done_q;
    logic              ready_q;
    logic              commit_pend;
    logic              xfer;
    logic              load_en;
`ifdef C2_CFG_PARITY_EN
    logic              err_q;
    logic              parity_ok;
`endif

    // ready is registered, so a transfer needs no combinational path from state
    assign xfer    = bus.cfg_valid && ready_q;
    // a restart or abort in the same cycle discards the offered bit
    assign load_en = (state == LOAD) && xfer && !bus.cfg_start && !bus.cfg_abort;

`ifdef C2_CFG_PARITY_EN
    // even parity over data plus parity bit
    assign parity_ok = ~(^shadow ^ bus.cfg_bit);
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.cfg_start) next_state = LOAD;
            end
            LOAD: begin
                if (bus.cfg_start)      next_state = LOAD;
                else if (bus.cfg_abort) next_state = IDLE;
                else if (xfer && (cnt == CW'(TOTAL - 1))) begin
`ifdef C2_CFG_PARITY_EN
                    next_state = PAR;
`else
                    next_state = ACTIVE;
`endif
                end
            end
`ifdef C2_CFG_PARITY_EN
            PAR: begin
                if (bus.cfg_start)      next_state = LOAD;
                else if (bus.cfg_abort) next_state = IDLE;
                else if (xfer)          next_state = parity_ok ? ACTIVE : ERROR;
            end
            ERROR: begin
                if (bus.cfg_start)      next_state = LOAD;
                else if (bus.cfg_abort) next_state = IDLE;
            end
`endif
            ACTIVE: begin
                if (bus.cfg_start)      next_state = LOAD;
                else if (bus.cfg_abort) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow;
        if (load_en) begin
            for (int i = 0; i < TOTAL; i++) begin
                if (cnt == CW'(i)) shadow_d[i] = bus.cfg_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            cell_cfg_q  <= '0;
            cells_en_q  <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            state  <= next_state;
            shadow <= shadow_d;

            if (bus.cfg_start) cnt <= '0;
            else if (load_en)  cnt <= cnt + 1'b1;

`ifdef C2_CFG_PARITY_EN
            ready_q <= (next_state == LOAD) || (next_state == PAR);
`else
            ready_q <= (next_state == LOAD);
`endif

            // Commit lands one edge after the final accepted bit, so the
            // entry into ACTIVE only arms it here.
            commit_pend <= (next_state == ACTIVE) && (state != ACTIVE);
            done_q      <= commit_pend;
            if (commit_pend) cell_cfg_q <= shadow;

            if (next_state != ACTIVE) cells_en_q <= 1'b0;
            else if (commit_pend)     cells_en_q <= 1'b1;
        end
    end

`ifdef C2_CFG_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          err_q <= 1'b0;
        else if (bus.cfg_start)                           err_q <= 1'b0;
        else if ((state == PAR) && (next_state == ERROR)) err_q <= 1'b1;
    end
    assign bus.cfg_err = err_q;
`else
    assign bus.cfg_err = 1'b0;
`endif

    assign bus.cfg_ready = ready_q;
    assign bus.cfg_done  = done_q;
    assign bus.cells_en  = cells_en_q;
    assign bus.cell_cfg  = cell_cfg_q;
endmodule

// File: tb/tb_c2_cfg_ctrl.sv
// tb_c2_cfg_ctrl: directed plus randomized bench for c2_cfg_ctrl (NUM_CELLS=2).
// A transaction-level model (queue of accepted bits, pending commit flag)
// predicts every output after each clock edge.
module tb_c2_cfg_ctrl;
    localparam int NUM_CELLS = 2;
    localparam int TOTAL     = 4 * NUM_CELLS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c2_cfg_ctrl_if #(.NUM_CELLS(NUM_CELLS)) bus ();
    c2_cfg_ctrl #(.NUM_CELLS(NUM_CELLS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model
    bit               m_load;   // accepting bits
    bit               m_parw;   // waiting for the parity bit
    bit               m_pend;   // commit happens on the next edge
    bit               m_done;
    bit               m_en;
    bit               m_err;
    logic [TOTAL-1:0] m_cfg;
    logic [TOTAL-1:0] m_pval;
    bit               q[$];

    function automatic logic [TOTAL-1:0] pack_q();
        logic [TOTAL-1:0] v;
        v = '0;
        for (int i = 0; i < q.size(); i++) v[i] = q[i];
        return v;
    endfunction

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_parw = 0; m_pend = 0; m_done = 0;
        m_en = 0; m_err = 0; m_cfg = '0; m_pval = '0;
        q.delete();
    endtask

    task automatic check_all(input string tag);
        check1({tag, ".ready"}, 32'(bus.cfg_ready), 32'(m_load));
        check1({tag, ".done"},  32'(bus.cfg_done),  32'(m_done));
        check1({tag, ".en"},    32'(bus.cells_en),  32'(m_en));
        check1({tag, ".cfg"},   32'(bus.cell_cfg),  32'(m_cfg));
        check1({tag, ".err"},   32'(bus.cfg_err),   32'(m_err));
    endtask

    // one clock cycle: drive, predict, clock, compare
    task automatic cycle(input bit s, input bit a, input bit v, input bit b, input string tag);
        bit xfer;
        bit pend_n;
        bit par;
        bus.cfg_start = s;
        bus.cfg_abort = a;
        bus.cfg_valid = v;
        bus.cfg_bit   = b;
        xfer   = v && m_load;
        m_done = m_pend;
        if (m_pend) m_cfg = m_pval;
        if (s || a) m_en = 0;
        else if (m_pend) m_en = 1;
        pend_n = 0;
        if (s) begin
            m_load = 1; m_parw = 0; m_err = 0;
            q.delete();
        end else if (a) begin
            m_load = 0; m_parw = 0;
        end else if (xfer) begin
            if (m_parw) begin
                par = b;
                foreach (q[i]) par ^= q[i];
                if (!par) begin
                    pend_n = 1; m_pval = pack_q();
                end else begin
                    m_err = 1;
                end
                m_load = 0; m_parw = 0;
            end else begin
                q.push_back(b);
                if (q.size() == TOTAL) begin
`ifdef C2_CFG_PARITY_EN
                    m_parw = 1;
`else
                    m_load = 0; pend_n = 1; m_pval = pack_q();
`endif
                end
            end
        end
        m_pend = pend_n;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 1'($urandom_range(0, 1)), tag);
    endtask

    task automatic send_word(input logic [TOTAL-1:0] w, input int nbits,
                             input int gap_at, input int gap_len, input string tag);
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_at) idle(gap_len, tag);
            cycle(0, 0, 1, w[i], tag);
        end
    endtask

    initial begin
        logic [TOTAL-1:0] rw;
        bus.cfg_start = 0; bus.cfg_abort = 0; bus.cfg_valid = 0; bus.cfg_bit = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: back-to-back stream 1,0,1,1,0,0,1,0
        cycle(1, 0, 0, 0, "t1.start");
        send_word(8'h4D, 8, -1, 0, "t1.bits");
        cycle(0, 0, 0, 0, "t1.commit");
        check1("t1.done_pulse", 32'(bus.cfg_done), 32'd1);
        check1("t1.cfg_const", 32'(bus.cell_cfg), 32'h4D);
        idle(1, "t1.after");
        check1("t1.done_once", 32'(bus.cfg_done), 32'd0);
        check1("t1.en_const", 32'(bus.cells_en), 32'd1);

        // 2: bits offered while not ready, then a gap of 3 idle cycles
        cycle(0, 0, 1, 1, "t2.noready");
        cycle(0, 0, 1, 0, "t2.noready");
        cycle(1, 0, 0, 0, "t2.start");
        send_word(8'h4D, 8, 4, 3, "t2.bits");
        idle(2, "t2.after");
        check1("t2.cfg_const", 32'(bus.cell_cfg), 32'h4D);
        check1("t2.en_const", 32'(bus.cells_en), 32'd1);

        // 3: abort mid-load keeps previous config
        cycle(1, 0, 0, 0, "t3.start");
        send_word(8'hA5, 5, -1, 0, "t3.bits");
        cycle(0, 1, 0, 0, "t3.abort");
        idle(3, "t3.after");
        check1("t3.cfg_const", 32'(bus.cell_cfg), 32'h4D);
        check1("t3.en_const", 32'(bus.cells_en), 32'd0);

        // 4: restart with a simultaneous transfer at bit 4
        cycle(1, 0, 0, 0, "t4.start");
        send_word(8'h0F, 4, -1, 0, "t4.bits");
        cycle(1, 0, 1, 1, "t4.restart");
        send_word(8'hFE, 8, -1, 0, "t4.bits2");
        idle(2, "t4.after");
        check1("t4.cfg_const", 32'(bus.cell_cfg), 32'hFE);

`ifdef C2_CFG_PARITY_EN
        // 5: parity good then parity bad
        cycle(1, 0, 0, 0, "t5.start");
        send_word(8'h4D, 8, -1, 0, "t5.bits");
        cycle(0, 0, 1, 0, "t5.par0");
        idle(2, "t5.after");
        check1("t5.cfg_good", 32'(bus.cell_cfg), 32'h4D);
        check1("t5.err_good", 32'(bus.cfg_err), 32'd0);
        cycle(1, 0, 0, 0, "t5.start2");
        send_word(8'hFE, 8, -1, 0, "t5.bits2");
        cycle(0, 0, 1, 0, "t5.par_bad");
        idle(2, "t5.after2");
        check1("t5.err_bad", 32'(bus.cfg_err), 32'd1);
        check1("t5.cfg_kept", 32'(bus.cell_cfg), 32'h4D);
        check1("t5.en_bad", 32'(bus.cells_en), 32'd0);
        cycle(0, 1, 0, 0, "t5.abort_err");
        check1("t5.err_kept", 32'(bus.cfg_err), 32'd1);
        cycle(1, 0, 0, 0, "t5.clear");
        check1("t5.err_clr", 32'(bus.cfg_err), 32'd0);
        cycle(0, 1, 0, 0, "t5.abort");
`endif

        // 6: asynchronous reset mid-load after a prior commit
        cycle(1, 0, 0, 0, "t6.start");
        send_word(8'h3C, 3, -1, 0, "t6.bits");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6.async");
        check1("t6.cfg_zero", 32'(bus.cell_cfg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rw = 8'($urandom);
        cycle(1, 0, 0, 0, "t6.fresh");
        send_word(rw, 8, 2, 1, "t6.fbits");
`ifdef C2_CFG_PARITY_EN
        cycle(0, 0, 1, ^rw, "t6.fpar");
`endif
        idle(2, "t6.fafter");
        check1("t6.fresh_cfg", 32'(bus.cell_cfg), 32'(rw));
        check1("t6.fresh_en", 32'(bus.cells_en), 32'd1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
